// File: rtl/mii_rx_frame_parser.sv
// Receive-side Ethernet frame parser: lane-to-octet assembly, preamble/SFD check,
// header extraction and payload streaming. Optional macro: RX_ADDR_FILTER_EN.
module mii_rx_frame_parser #(
    parameter int          DW      = 4,
    parameter int          MIN_PRE = 7,
    parameter logic [47:0] MY_MAC  = 48'h54ff01212324
) (
    input  logic          clk,
    input  logic          SW0,
    input  logic          rx_en,
    input  logic [DW-1:0] rx_d,
    output logic [47:0]   dst_mac,
    output logic [47:0]   src_mac,
    output logic [15:0]   eth_type,
    output logic          hdr_valid,
    output logic [7:0]    pl_data,
    output logic          pl_valid,
    output logic          pl_last,
    output logic [10:0]   pl_len,
    output logic          pre_err,
    output logic          runt_err,
    output logic          align_err
);
    // state | meaning
    // IDLE  | waiting for first preamble octet
    // PRE   | counting 0x55 octets, waiting for SFD
    // HDR   | collecting 14 header octets
    // PAY   | streaming payload through a one-octet holding register
    // DROP  | frame rejected, ignore until rx_en falls
    typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, DROP} state_t;

    if (!(DW == 4 || DW == 8)) begin : g_bad_dw
        $error("DW must be 4 or 8");
    end
    if (MIN_PRE < 1 || MIN_PRE > 7) begin : g_bad_min_pre
        $error("MIN_PRE must be in 1..7");
    end
    if (MY_MAC[40]) begin : g_bad_mac
        $error("MY_MAC must be a unicast address");
    end

    logic       phase;
    logic       octet_done;
    logic [7:0] octet;

    if (DW == 4) begin : g_nib
        logic [3:0] nib_lo;
        always_ff @(posedge clk or negedge SW0) begin
            if (!SW0) begin
                phase  <= 1'b0;
                nib_lo <= 4'h0;
            end else if (!rx_en) begin
                phase  <= 1'b0;
            end else begin
                phase <= ~phase;
                if (!phase) nib_lo <= rx_d;
            end
        end
        assign octet_done = rx_en & phase;
        assign octet      = {rx_d, nib_lo};
    end else begin : g_byte
        assign phase      = 1'b0;
        assign octet_done = rx_en;
        assign octet      = rx_d;
    end

    state_t        state, state_nxt;
    logic [2:0]    pre_cnt, pre_cnt_nxt;
    logic [3:0]    hdr_cnt, hdr_cnt_nxt;
    logic          held_vld, held_vld_nxt;
    logic [7:0]    held;
    logic [103:0]  hdr_sr;
    logic [111:0]  hdr_full;
    logic [10:0]   pl_cnt;
    logic [11:0]   pl_cnt_inc;
    logic [10:0]   pl_cnt_sat;
    logic          addr_ok;
    logic          emit, emit_last, hdr_load;
    logic          pre_err_nxt, runt_err_nxt, align_err_nxt;

    assign hdr_full   = {hdr_sr, octet};
    assign pl_cnt_inc = {1'b0, pl_cnt} + 12'd1;
    assign pl_cnt_sat = pl_cnt_inc[11] ? 11'h7ff : pl_cnt_inc[10:0];

`ifdef RX_ADDR_FILTER_EN
    assign addr_ok = (hdr_full[111:64] == MY_MAC) || (hdr_full[111:64] == 48'hffffffffffff);
`else
    assign addr_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge SW0) begin
        if (!SW0) begin
            state    <= IDLE;
            pre_cnt  <= 3'd0;
            hdr_cnt  <= 4'd0;
            held_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            pre_cnt  <= pre_cnt_nxt;
            hdr_cnt  <= hdr_cnt_nxt;
            held_vld <= held_vld_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pre_cnt_nxt   = pre_cnt;
        hdr_cnt_nxt   = hdr_cnt;
        held_vld_nxt  = held_vld;
        emit          = 1'b0;
        emit_last     = 1'b0;
        hdr_load      = 1'b0;
        pre_err_nxt   = 1'b0;
        runt_err_nxt  = 1'b0;
        align_err_nxt = 1'b0;
        if (!rx_en) begin
            // end of frame: a half-assembled octet is an alignment fault
            align_err_nxt = phase;
            case (state)
                PAY: begin
                    emit      = held_vld;
                    emit_last = held_vld;
                end
                HDR:     runt_err_nxt = 1'b1;
                PRE:     pre_err_nxt  = 1'b1;
                default: ;
            endcase
            state_nxt    = IDLE;
            pre_cnt_nxt  = 3'd0;
            hdr_cnt_nxt  = 4'd0;
            held_vld_nxt = 1'b0;
        end else if (octet_done) begin
            case (state)
                IDLE: begin
                    if (octet == 8'h55) begin
                        state_nxt   = PRE;
                        pre_cnt_nxt = 3'd1;
                    end else begin
                        state_nxt   = DROP;
                        pre_err_nxt = 1'b1;
                    end
                end
                PRE: begin
                    if (octet == 8'h55) begin
                        if (pre_cnt != 3'd7) pre_cnt_nxt = pre_cnt + 3'd1;
                    end else if (octet == 8'hd5 && pre_cnt >= 3'(MIN_PRE)) begin
                        state_nxt   = HDR;
                        hdr_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt   = DROP;
                        pre_err_nxt = 1'b1;
                    end
                end
                HDR: begin
                    if (hdr_cnt == 4'd13) begin
                        hdr_cnt_nxt = 4'd0;
                        if (addr_ok) begin
                            hdr_load     = 1'b1;
                            state_nxt    = PAY;
                            held_vld_nxt = 1'b0;
                        end else begin
                            state_nxt = DROP;
                        end
                    end else begin
                        hdr_cnt_nxt = hdr_cnt + 4'd1;
                    end
                end
                PAY: begin
                    emit         = held_vld;
                    held_vld_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge SW0) begin
        if (!SW0) begin
            held      <= 8'h00;
            hdr_sr    <= '0;
            dst_mac   <= '0;
            src_mac   <= '0;
            eth_type  <= '0;
            hdr_valid <= 1'b0;
            pl_data   <= 8'h00;
            pl_valid  <= 1'b0;
            pl_last   <= 1'b0;
            pl_len    <= '0;
            pl_cnt    <= '0;
            pre_err   <= 1'b0;
            runt_err  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            hdr_valid <= hdr_load;
            pl_valid  <= emit;
            pl_last   <= emit_last;
            pre_err   <= pre_err_nxt;
            runt_err  <= runt_err_nxt;
            align_err <= align_err_nxt;
            if (state == HDR && octet_done) hdr_sr <= hdr_full[103:0];
            if (state == PAY && octet_done) held <= octet;
            if (hdr_load) begin
                dst_mac  <= hdr_full[111:64];
                src_mac  <= hdr_full[63:16];
                eth_type <= hdr_full[15:0];
                pl_cnt   <= '0;
            end
            if (emit) begin
                pl_data <= held;
                if (emit_last) begin
                    pl_len <= pl_cnt_sat;
                    pl_cnt <= '0;
                end else begin
                    pl_cnt <= pl_cnt_sat;
                end
            end
        end
    end

endmodule
